pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Drives the enable/flush controls of the negedge-clocked pipeline registers (IF/ID, ID/EX,
//  EX/MEM, MEM/WB) and the PC register. Detects load-use hazards, taken-branch redirects and
//  data-memory wait states. Sequences multi-cycle stalls with a small FSM and keeps
//  saturating stall/flush event counters for debug.
// PARAMETERS
//  ADDR_W        5   register-file address width
//  LOAD_BUBBLES  1   bubbles inserted per load-use hazard; legal 1..3
//  CNT_W         16  width of the event counters
// PORTS
//  clk            in   1       system clock; state and counters update on posedge
//  reset          in   1       synchronous, active-high reset
//  id_rs          in   ADDR_W  rs of the instruction in ID
//  id_rt          in   ADDR_W  rt of the instruction in ID
//  id_uses_rt     in   1       ID instruction reads rt
//  ex_rd          in   ADDR_W  destination of the instruction in EX
//  ex_mem_read    in   1       EX instruction is a load
//  branch_taken   in   1       branch/jump in ID resolved taken
//  mem_access     in   1       MEM-stage instruction accesses data memory
//  mem_ready      in   1       data memory completes the access this cycle
//  pc_enable      out  1       PC load enable
//  if_id_enable   out  1       IF/ID enable
//  if_id_flush    out  1       IF/ID loads a NOP
//  id_ex_enable   out  1       ID/EX enable
//  id_ex_flush    out  1       ID/EX loads a bubble (control zeroed)
//  ex_mem_enable  out  1       EX/MEM enable
//  mem_wb_enable  out  1       MEM/WB enable
//  stall_cycles   out  CNT_W   cycles with pc_enable==0
//  flush_events   out  CNT_W   cycles with if_id_flush==1
//  hz_state       out  2       FSM state: 0=RUN, 1=LOAD_STALL, 2=MEM_WAIT
// BEHAVIOUR
//  - Control outputs are combinational (Mealy) from state and inputs, valid in the same cycle.
//  - reset==1 forces: all enables=1, both flushes=1, and the state register to RUN. The next
//    posedge clears counters, the bubble counter and the resume register. This also applies
//    mid-stall.
//  - load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
//  - freeze = mem_access & ~mem_ready.
//  - Default outputs: all enables=1, flushes=0.
//  - Stall pattern: pc_enable=0, if_id_enable=0, id_ex_flush=1; other enables stay 1.
//  - RUN:
//    - freeze: all enables=0, flushes=0; save resume=RUN; go to MEM_WAIT.
//    - else load_use: apply the stall pattern. If LOAD_BUBBLES>1, load bcnt=LOAD_BUBBLES-1 and
//      go to LOAD_STALL; otherwise stay in RUN.
//    - else branch_taken: if_id_flush=1 with all enables=1.
//    - load_use takes priority over branch_taken in the same cycle. The branch is held in ID
//      and re-resolved after the stall.
//  - LOAD_STALL:
//    - Apply the stall pattern and ignore branch_taken.
//    - bcnt decrements each cycle; after the cycle with bcnt==1, go to RUN.
//    - freeze overrides: all enables=0, bcnt holds, save resume=LOAD_STALL, go to MEM_WAIT.
//  - MEM_WAIT:
//    - All enables=0 and flushes=0 while freeze is high.
//    - In the first cycle with freeze==0, outputs are as in the resume state for the current
//      inputs, and the next state follows the resume state's rules.
//  - Freeze never drops or duplicates a bubble. Flush never asserts while an enable is 0.
//  - Counters:
//    - stall_cycles += 1 each cycle pc_enable==0 and reset==0.
//    - flush_events += 1 each cycle if_id_flush==1 and reset==0.
//    - Both saturate at all-ones; no wrap.
// TESTING
//  1 ex_mem_read=1, ex_rd=8, id_rs=8, LOAD_BUBBLES=1
//    -> one cycle pc_enable=0, id_ex_flush=1; next cycle (ex_rd=0) all enables=1;
//       stall_cycles=1.
//  2 LOAD_BUBBLES=2, same hazard
//    -> stall pattern for 2 cycles, hz_state 0->1->0, stall_cycles=2.
//  3 load_use and branch_taken in the same cycle
//    -> stall, no flush; the following cycle with branch_taken=1 gives if_id_flush=1 and
//       flush_events=1.
//  4 mem_access=1, mem_ready=0 for 3 cycles during LOAD_STALL
//    -> all enables=0 for 3 cycles, hz_state=2, bcnt held; resumes LOAD_STALL, then RUN.
//  5 ex_rd=0 with ex_mem_read=1 and id_rs=0
//    -> no stall.
//  6 reset=1 mid-LOAD_STALL
//    -> all enables=1 and flushes=1 immediately; after the edge, hz_state=0 and counters=0.
//  7 force stall_cycles to 16'hFFFF, then stall
//    -> stall_cycles stays at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall controller for a five-stage pipeline whose stage
//   registers (IF/ID, ID/EX, EX/MEM, MEM/WB) are clocked on negedge. This
//   block runs on posedge and produces their enable/flush controls plus the
//   PC load enable. It resolves load-use hazards (bubble insertion),
//   taken-branch redirects (IF/ID flush) and data-memory wait states (full
//   pipeline freeze), sequencing multi-bubble stalls with a small FSM, and
//   keeps saturating stall/flush event counters for debug.
//
// Parameters
//   ADDR_W        register-file address width
//   LOAD_BUBBLES  bubbles inserted per load-use hazard (1..3)
//   CNT_W         width of the debug event counters
//
// Ports
//   clk, reset         posedge clock, synchronous active-high reset
//   id_rs, id_rt       source registers of the instruction in ID
//   id_uses_rt         ID instruction actually reads rt
//   ex_rd, ex_mem_read destination / is-load of the instruction in EX
//   branch_taken       branch/jump in ID resolved taken
//   mem_access         MEM-stage instruction touches data memory
//   mem_ready          data memory completes the access this cycle
//   pc_enable .. mem_wb_enable, if_id_flush, id_ex_flush
//                      combinational pipeline-register controls
//   stall_cycles       saturating count of cycles with pc_enable==0
//   flush_events       saturating count of cycles with if_id_flush==1
//   hz_state           FSM state: 0=RUN, 1=LOAD_STALL, 2=MEM_WAIT
module pipeline_hazard_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              branch_taken,
  input  logic              mem_access,
  input  logic              mem_ready,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              id_ex_enable,
  output logic              id_ex_flush,
  output logic              ex_mem_enable,
  output logic              mem_wb_enable,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events,
  output logic [1:0]        hz_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  // Remaining bubbles after the first one, loaded when a hazard is detected.
  localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);

  state_t     state, state_nxt;
  state_t     resume, resume_nxt;
  state_t     eff_state;
  logic [1:0] bcnt, bcnt_nxt;
  logic       load_use;
  logic       freeze;
  logic       do_hold;
  logic       do_stall;
  logic       do_branch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign freeze   = mem_access && !mem_ready;

  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    bcnt_nxt   = bcnt;
    do_hold    = 1'b0;
    do_stall   = 1'b0;
    do_branch  = 1'b0;
    // On the cycle the memory wait ends, behave exactly like the state that
    // was interrupted, so no bubble is dropped or duplicated.
    eff_state  = ((state == MEM_WAIT) && !freeze) ? resume : state;

    if ((state == MEM_WAIT) && freeze) begin
      do_hold = 1'b1;
    end else begin
      unique case (eff_state)
        LOAD_STALL: begin
          if (freeze) begin
            do_hold    = 1'b1;
            resume_nxt = LOAD_STALL;
            state_nxt  = MEM_WAIT;
          end else begin
            // Branches in ID are not acted on here; the branch stays in ID
            // and is re-resolved once the stall completes.
            do_stall  = 1'b1;
            bcnt_nxt  = bcnt - 1'b1;
            state_nxt = (bcnt <= 2'd1) ? RUN : LOAD_STALL;
          end
        end
        default: begin
          state_nxt = RUN;
          if (freeze) begin
            do_hold    = 1'b1;
            resume_nxt = RUN;
            state_nxt  = MEM_WAIT;
          end else if (load_use) begin
            do_stall = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              bcnt_nxt  = BCNT_INIT;
              state_nxt = LOAD_STALL;
            end
          end else if (branch_taken) begin
            do_branch = 1'b1;
          end
        end
      endcase
    end

    pc_enable     = !(do_hold || do_stall);
    if_id_enable  = !(do_hold || do_stall);
    id_ex_enable  = !do_hold;
    ex_mem_enable = !do_hold;
    mem_wb_enable = !do_hold;
    if_id_flush   = do_branch;
    id_ex_flush   = do_stall;

    // Reset loads NOPs everywhere: every register enabled and both flushed.
    if (reset) begin
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      id_ex_enable  = 1'b1;
      ex_mem_enable = 1'b1;
      mem_wb_enable = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      resume       <= RUN;
      bcnt         <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state        <= state_nxt;
      resume       <= resume_nxt;
      bcnt         <= bcnt_nxt;
      stall_cycles <= sat_inc(stall_cycles, !pc_enable);
      flush_events <= sat_inc(flush_events, if_id_flush);
    end
  end

  assign hz_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  // {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] C_NORM  = 7'b1101011;
  localparam logic [6:0] C_STALL = 7'b0001111;
  localparam logic [6:0] C_HOLD  = 7'b0000000;
  localparam logic [6:0] C_BR    = 7'b1111011;
  localparam logic [6:0] C_RST   = 7'b1111111;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [1:0]  hz;
    logic [15:0] sc;
    logic [15:0] fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_access, mem_ready;

  logic [3:0]  pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en;
  logic [1:0]  hzv [4];
  logic [15:0] scv [4];
  logic [15:0] fev [4];
  logic [2:0]  sc_sat, fe_sat;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [1:0]  sel;
  logic [15:0] m_sc, m_fe, m_max;

  always #5 clk = ~clk;

  // Instances 0..2 use LOAD_BUBBLES 1..3; instance 3 has 3-bit counters.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_hazard_ctrl #(.ADDR_W(5), .LOAD_BUBBLES(g + 1), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .branch_taken(branch_taken), .mem_access(mem_access), .mem_ready(mem_ready),
      .pc_enable(pc_en[g]), .if_id_enable(ifid_en[g]), .if_id_flush(ifid_fl[g]),
      .id_ex_enable(idex_en[g]), .id_ex_flush(idex_fl[g]),
      .ex_mem_enable(exmem_en[g]), .mem_wb_enable(memwb_en[g]),
      .stall_cycles(scv[g]), .flush_events(fev[g]), .hz_state(hzv[g])
    );
  end

  pipeline_hazard_ctrl #(.ADDR_W(5), .LOAD_BUBBLES(1), .CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_enable(pc_en[3]), .if_id_enable(ifid_en[3]), .if_id_flush(ifid_fl[3]),
    .id_ex_enable(idex_en[3]), .id_ex_flush(idex_fl[3]),
    .ex_mem_enable(exmem_en[3]), .mem_wb_enable(memwb_en[3]),
    .stall_cycles(sc_sat), .flush_events(fe_sat), .hz_state(hzv[3])
  );

  assign scv[3] = {13'd0, sc_sat};
  assign fev[3] = {13'd0, fe_sat};

  function automatic logic [6:0] obs_ctl(input logic [1:0] s);
    return {pc_en[s], ifid_en[s], ifid_fl[s], idex_en[s], idex_fl[s],
            exmem_en[s], memwb_en[s]};
  endfunction

  task automatic set_sel(input logic [1:0] s);
    sel   = s;
    m_max = (s == 2'd3) ? 16'd7 : 16'hFFFF;
  endtask

  task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs, input logic urt, input logic [4:0] rt,
                       input logic bt, input logic ma, input logic rdy);
    reset        = r;
    ex_mem_read  = mr;
    ex_rd        = rd;
    id_rs        = rs;
    id_uses_rt   = urt;
    id_rt        = rt;
    branch_taken = bt;
    mem_access   = ma;
    mem_ready    = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hazard(input logic bt);
    drive(1'b0, 1'b1, 5'd8, 5'd8, 1'b0, 5'd0, bt, 1'b0, 1'b0);
  endtask

  // Push the expected outputs for this cycle, then advance the counter model.
  task automatic expect_cyc(input logic [6:0] c, input logic [1:0] h);
    sbq.push_back('{ctl: c, hz: h, sc: m_sc, fe: m_fe});
    if (reset) begin
      m_sc = '0;
      m_fe = '0;
    end else begin
      if (!c[6] && (m_sc != m_max)) m_sc = m_sc + 16'd1;
      if (c[4] && (m_fe != m_max)) m_fe = m_fe + 16'd1;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    m_sc = '0;
    m_fe = '0;
    idle();
  endtask

  task automatic test_reset();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      set_sel(2'(s));
      m_sc = '0;
      m_fe = '0;
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
          expect_cyc(C_RST, 2'd0);
        end else begin
          idle();
          expect_cyc(C_NORM, 2'd0);
        end
        #2;
        e = sbq.pop_front();
        total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL reset inst=%0d k=%0d ctl got=%b want=%b", sel, k, obs_ctl(sel), e.ctl); end
        total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL reset inst=%0d k=%0d hz got=%0d want=%0d", sel, k, hzv[sel], e.hz); end
        total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL reset inst=%0d k=%0d stall_cycles got=%0d want=%0d", sel, k, scv[sel], e.sc); end
        total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL reset inst=%0d k=%0d flush_events got=%0d want=%0d", sel, k, fev[sel], e.fe); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    set_sel(2'd0);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin hazard(1'b0); expect_cyc(C_STALL, 2'd0); end
        1: begin idle(); expect_cyc(C_NORM, 2'd0); end
        2: begin drive(1'b0, 1'b1, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); expect_cyc(C_STALL, 2'd0); end
        3: begin drive(1'b0, 1'b1, 5'd8, 5'd3, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0); expect_cyc(C_NORM, 2'd0); end
        4: begin drive(1'b0, 1'b0, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0); expect_cyc(C_NORM, 2'd0); end
        default: begin idle(); expect_cyc(C_NORM, 2'd0); end
      endcase
      #2;
      e = sbq.pop_front();
      total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL load_use k=%0d ctl got=%b want=%b", k, obs_ctl(sel), e.ctl); end
      total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL load_use k=%0d hz got=%0d want=%0d", k, hzv[sel], e.hz); end
      total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL load_use k=%0d stall_cycles got=%0d want=%0d", k, scv[sel], e.sc); end
      total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL load_use k=%0d flush_events got=%0d want=%0d", k, fev[sel], e.fe); end
      @(negedge clk);
    end
  endtask

  // Instances 1 and 2 (2 and 3 bubbles); branch held during the stall.
  task automatic test_multi_bubble();
    exp_t e;
    for (int s = 1; s <= 2; s++) begin
      set_sel(2'(s));
      do_reset();
      for (int k = 0; k <= s + 2; k++) begin
        if (k == 0) begin
          hazard(1'b0); expect_cyc(C_STALL, 2'd0);
        end else if (k <= s) begin
          drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
          expect_cyc(C_STALL, 2'd1);
        end else if (k == s + 1) begin
          drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
          expect_cyc(C_BR, 2'd0);
        end else begin
          idle(); expect_cyc(C_NORM, 2'd0);
        end
        #2;
        e = sbq.pop_front();
        total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL multi_bubble inst=%0d k=%0d ctl got=%b want=%b", sel, k, obs_ctl(sel), e.ctl); end
        total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL multi_bubble inst=%0d k=%0d hz got=%0d want=%0d", sel, k, hzv[sel], e.hz); end
        total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL multi_bubble inst=%0d k=%0d stall_cycles got=%0d want=%0d", sel, k, scv[sel], e.sc); end
        total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL multi_bubble inst=%0d k=%0d flush_events got=%0d want=%0d", sel, k, fev[sel], e.fe); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branch_priority();
    exp_t e;
    set_sel(2'd0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin hazard(1'b1); expect_cyc(C_STALL, 2'd0); end
        1: begin drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); expect_cyc(C_BR, 2'd0); end
        default: begin idle(); expect_cyc(C_NORM, 2'd0); end
      endcase
      #2;
      e = sbq.pop_front();
      total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL branch_prio k=%0d ctl got=%b want=%b", k, obs_ctl(sel), e.ctl); end
      total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL branch_prio k=%0d hz got=%0d want=%0d", k, hzv[sel], e.hz); end
      total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL branch_prio k=%0d stall_cycles got=%0d want=%0d", k, scv[sel], e.sc); end
      total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL branch_prio k=%0d flush_events got=%0d want=%0d", k, fev[sel], e.fe); end
      @(negedge clk);
    end
  endtask

  // Freeze inside LOAD_STALL (instance 1), then freeze from RUN (instance 0).
  task automatic test_freeze();
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      set_sel((p == 0) ? 2'd1 : 2'd0);
      do_reset();
      for (int k = 0; k < 6; k++) begin
        if (p == 0) begin
          case (k)
            0: begin hazard(1'b0); expect_cyc(C_STALL, 2'd0); end
            1: begin drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); expect_cyc(C_HOLD, 2'd1); end
            2, 3: begin drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); expect_cyc(C_HOLD, 2'd2); end
            4: begin drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); expect_cyc(C_STALL, 2'd2); end
            default: begin idle(); expect_cyc(C_NORM, 2'd0); end
          endcase
        end else begin
          case (k)
            0: begin drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); expect_cyc(C_HOLD, 2'd0); end
            1: begin drive(1'b0, 1'b1, 5'd8, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); expect_cyc(C_HOLD, 2'd2); end
            2: begin drive(1'b0, 1'b1, 5'd8, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); expect_cyc(C_STALL, 2'd2); end
            default: begin idle(); expect_cyc(C_NORM, 2'd0); end
          endcase
        end
        #2;
        e = sbq.pop_front();
        total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL freeze p=%0d k=%0d ctl got=%b want=%b", p, k, obs_ctl(sel), e.ctl); end
        total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL freeze p=%0d k=%0d hz got=%0d want=%0d", p, k, hzv[sel], e.hz); end
        total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL freeze p=%0d k=%0d stall_cycles got=%0d want=%0d", p, k, scv[sel], e.sc); end
        total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL freeze p=%0d k=%0d flush_events got=%0d want=%0d", p, k, fev[sel], e.fe); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_rd_zero();
    exp_t e;
    set_sel(2'd0);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        1: drive(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        2: drive(1'b0, 1'b1, 5'd8, 5'd3, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
        default: idle();
      endcase
      expect_cyc(C_NORM, 2'd0);
      #2;
      e = sbq.pop_front();
      total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL rd_zero k=%0d ctl got=%b want=%b", k, obs_ctl(sel), e.ctl); end
      total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL rd_zero k=%0d hz got=%0d want=%0d", k, hzv[sel], e.hz); end
      total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL rd_zero k=%0d stall_cycles got=%0d want=%0d", k, scv[sel], e.sc); end
      total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL rd_zero k=%0d flush_events got=%0d want=%0d", k, fev[sel], e.fe); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    set_sel(2'd1);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0, 2: begin hazard(1'b0); expect_cyc(C_STALL, 2'd0); end
        1, 3: begin idle(); expect_cyc(C_STALL, 2'd1); end
        default: begin idle(); expect_cyc(C_NORM, 2'd0); end
      endcase
      #2;
      e = sbq.pop_front();
      total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL back_to_back k=%0d ctl got=%b want=%b", k, obs_ctl(sel), e.ctl); end
      total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL back_to_back k=%0d hz got=%0d want=%0d", k, hzv[sel], e.hz); end
      total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL back_to_back k=%0d stall_cycles got=%0d want=%0d", k, scv[sel], e.sc); end
      total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL back_to_back k=%0d flush_events got=%0d want=%0d", k, fev[sel], e.fe); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    set_sel(2'd2);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin hazard(1'b0); expect_cyc(C_STALL, 2'd0); end
        1: begin idle(); expect_cyc(C_STALL, 2'd1); end
        2: begin drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); expect_cyc(C_RST, 2'd1); end
        default: begin idle(); expect_cyc(C_NORM, 2'd0); end
      endcase
      #2;
      e = sbq.pop_front();
      total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL reset_mid k=%0d ctl got=%b want=%b", k, obs_ctl(sel), e.ctl); end
      total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL reset_mid k=%0d hz got=%0d want=%0d", k, hzv[sel], e.hz); end
      total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL reset_mid k=%0d stall_cycles got=%0d want=%0d", k, scv[sel], e.sc); end
      total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL reset_mid k=%0d flush_events got=%0d want=%0d", k, fev[sel], e.fe); end
      @(negedge clk);
    end
  endtask

  // 3-bit counters: both must stop at 7 rather than wrap.
  task automatic test_saturation();
    exp_t e;
    set_sel(2'd3);
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      if (k < 10) begin
        hazard(1'b0); expect_cyc(C_STALL, 2'd0);
      end else if (k < 20) begin
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        expect_cyc(C_BR, 2'd0);
      end else begin
        idle(); expect_cyc(C_NORM, 2'd0);
      end
      #2;
      e = sbq.pop_front();
      total++; if (obs_ctl(sel) !== e.ctl) begin bad++; $display("FAIL saturation k=%0d ctl got=%b want=%b", k, obs_ctl(sel), e.ctl); end
      total++; if (hzv[sel] !== e.hz) begin bad++; $display("FAIL saturation k=%0d hz got=%0d want=%0d", k, hzv[sel], e.hz); end
      total++; if (scv[sel] !== e.sc) begin bad++; $display("FAIL saturation k=%0d stall_cycles got=%0d want=%0d", k, scv[sel], e.sc); end
      total++; if (fev[sel] !== e.fe) begin bad++; $display("FAIL saturation k=%0d flush_events got=%0d want=%0d", k, fev[sel], e.fe); end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    m_sc = '0;
    m_fe = '0;
    set_sel(2'd0);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_multi_bubble();
    test_branch_priority();
    test_freeze();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
